// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN (see dmem_arbiter).
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam logic       OWNER_CPU  = 1'b0;
   localparam logic       OWNER_DMA  = 1'b1;
   localparam logic [3:0] SMASK_WORD = 4'b0000;

   // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=CPU, req[1]=DMA. On contention the port
// that did not win last time is granted; last_grant doubles as the current owner.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       last_grant
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (&req) begin
            gnt = (last_grant == OWNER_DMA) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant <= OWNER_DMA;
      end else if (|gnt) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU load/store path and the DMA loader.
// Defining DMEM_ARB_STATS_EN adds saturating grant/conflict counters.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner's request fields
//   ISSUE | one-cycle mem read/write enable pulse, load latency counter
//   WAIT  | count memory latency, capture read data on terminal count
//   RESP  | release CPU stall or pulse dma_done_o
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cpu_r_ena_i,
   input  logic          cpu_w_ena_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_w_data_i,
   input  logic [3:0]    cpu_sign_mask_i,
   output logic [DW-1:0] cpu_r_data_o,
   output logic          cpu_stall_o,
   input  logic          dma_valid_i,
   output logic          dma_ready_o,
   input  logic          dma_we_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_w_data_i,
   output logic          dma_done_o,
   output logic [DW-1:0] dma_r_data_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_w_data_o,
   output logic [3:0]    mem_sign_mask_o,
   output logic          mem_r_ena_o,
   output logic          mem_w_ena_o,
   input  logic [DW-1:0] mem_r_data_i
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   stat_cpu_grants_o,
   output logic [15:0]   stat_dma_grants_o,
   output logic [15:0]   stat_conflicts_o
`endif
);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       gnt;
   logic             owner_q;
   logic             we_q;
   logic             cpu_req;
   logic             arb_en;
   logic [DW-1:0]    cpu_rdata_q;
   logic [DW-1:0]    dma_rdata_q;

   assign cpu_req = cpu_r_ena_i | cpu_w_ena_i;
   assign arb_en  = (state_q == IDLE);

   rr_arb2 u_rr_arb2 (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req        ({dma_valid_i, cpu_req}),
      .en         (arb_en),
      .gnt        (gnt),
      .last_grant (owner_q)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|gnt) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request fields are latched at grant so a requester may drop or change them afterwards.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_addr_o      <= '0;
         mem_w_data_o    <= '0;
         mem_sign_mask_o <= '0;
         we_q            <= 1'b0;
         cnt_q           <= '0;
         cpu_rdata_q     <= '0;
         dma_rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt[OWNER_CPU]) begin
                  mem_addr_o      <= cpu_addr_i;
                  mem_w_data_o    <= cpu_w_data_i;
                  mem_sign_mask_o <= cpu_sign_mask_i;
                  we_q            <= cpu_w_ena_i;
               end else if (gnt[OWNER_DMA]) begin
                  mem_addr_o      <= dma_addr_i;
                  mem_w_data_o    <= dma_w_data_i;
                  mem_sign_mask_o <= SMASK_WORD;
                  we_q            <= dma_we_i;
               end
            end
            ISSUE: cnt_q <= CNT_W'(MEM_LAT - 1);
            WAIT: begin
               if (cnt_q == '0) begin
                  if (!we_q) begin
                     if (owner_q == OWNER_CPU) cpu_rdata_q <= mem_r_data_i;
                     else                      dma_rdata_q <= mem_r_data_i;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_r_ena_o  = (state_q == ISSUE) && !we_q;
   assign mem_w_ena_o  = (state_q == ISSUE) && we_q;
   assign cpu_stall_o  = cpu_req && !((state_q == RESP) && (owner_q == OWNER_CPU));
   assign dma_ready_o  = gnt[OWNER_DMA];
   assign dma_done_o   = (state_q == RESP) && (owner_q == OWNER_DMA);
   assign cpu_r_data_o = cpu_rdata_q;
   assign dma_r_data_o = dma_rdata_q;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_cpu_grants_o <= '0;
         stat_dma_grants_o <= '0;
         stat_conflicts_o  <= '0;
      end else begin
         if (gnt[OWNER_CPU] && (stat_cpu_grants_o != 16'hFFFF))
            stat_cpu_grants_o <= stat_cpu_grants_o + 16'd1;
         if (gnt[OWNER_DMA] && (stat_dma_grants_o != 16'hFFFF))
            stat_dma_grants_o <= stat_dma_grants_o + 16'd1;
         if (arb_en && cpu_req && dma_valid_i && (stat_conflicts_o != 16'hFFFF))
            stat_conflicts_o <= stat_conflicts_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-timing reference model.
// Build with DMEM_ARB_STATS_EN defined to also cover the statistics counters.
module tb_dmem_arbiter;

   localparam int L  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cpu_r_ena_i = 1'b0, cpu_w_ena_i = 1'b0;
   logic [AW-1:0] cpu_addr_i = '0;
   logic [DW-1:0] cpu_w_data_i = '0;
   logic [3:0]    cpu_sign_mask_i = '0;
   logic [DW-1:0] cpu_r_data_o;
   logic          cpu_stall_o;
   logic          dma_valid_i = 1'b0, dma_we_i = 1'b0;
   logic          dma_ready_o;
   logic [AW-1:0] dma_addr_i = '0;
   logic [DW-1:0] dma_w_data_i = '0;
   logic          dma_done_o;
   logic [DW-1:0] dma_r_data_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_w_data_o;
   logic [3:0]    mem_sign_mask_o;
   logic          mem_r_ena_o, mem_w_ena_o;
   logic [DW-1:0] mem_r_data_i = '0;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   stat_cpu_grants_o, stat_dma_grants_o, stat_conflicts_o;
`endif

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.MEM_LAT(L), .AW(AW), .DW(DW)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .cpu_r_ena_i     (cpu_r_ena_i),
      .cpu_w_ena_i     (cpu_w_ena_i),
      .cpu_addr_i      (cpu_addr_i),
      .cpu_w_data_i    (cpu_w_data_i),
      .cpu_sign_mask_i (cpu_sign_mask_i),
      .cpu_r_data_o    (cpu_r_data_o),
      .cpu_stall_o     (cpu_stall_o),
      .dma_valid_i     (dma_valid_i),
      .dma_ready_o     (dma_ready_o),
      .dma_we_i        (dma_we_i),
      .dma_addr_i      (dma_addr_i),
      .dma_w_data_i    (dma_w_data_i),
      .dma_done_o      (dma_done_o),
      .dma_r_data_o    (dma_r_data_o),
      .mem_addr_o      (mem_addr_o),
      .mem_w_data_o    (mem_w_data_o),
      .mem_sign_mask_o (mem_sign_mask_o),
      .mem_r_ena_o     (mem_r_ena_o),
      .mem_w_ena_o     (mem_w_ena_o),
      .mem_r_data_i    (mem_r_data_i)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_cpu_grants_o (stat_cpu_grants_o),
      .stat_dma_grants_o (stat_dma_grants_o),
      .stat_conflicts_o  (stat_conflicts_o)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a granted transaction occupies cycles t0+1 .. t0+2+L,
   // issuing at t0+1 and responding at t0+2+L.
   int          cyc = 0;
   bit          busy;
   int          t0;
   bit          m_owner, m_we, last;
   logic [31:0] m_addr, m_wdata, exp_cpu_rd, exp_dma_rd;
   logic [3:0]  m_mask;
   int          s_cpu, s_dma, s_conf;
   logic [31:0] ref_mem [16];
   logic [31:0] phys    [16];
   int          rd_due;
   logic [31:0] rd_val;
   bit          cpu_active, dma_pend;

   function automatic int widx(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_reset();
      busy = 0; t0 = 0; m_owner = 0; m_we = 0; last = 1;
      m_addr = '0; m_wdata = '0; m_mask = '0;
      exp_cpu_rd = '0; exp_dma_rd = '0;
      s_cpu = 0; s_dma = 0; s_conf = 0;
      rd_due = -100;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic eval();
      bit cpu_req, issue, resp, g_cpu, g_dma;
      mem_r_data_i = (cyc == rd_due) ? rd_val : 32'($urandom);
      #1;
      cpu_req = cpu_r_ena_i | cpu_w_ena_i;
      issue   = busy && (cyc == t0 + 1);
      resp    = busy && (cyc == t0 + 2 + L);
      g_cpu   = !busy && cpu_req && (!dma_valid_i || last);
      g_dma   = !busy && dma_valid_i && !g_cpu;
      if (resp && !m_we) begin
         if (!m_owner) exp_cpu_rd = ref_mem[widx(m_addr)];
         else          exp_dma_rd = ref_mem[widx(m_addr)];
      end
      check("cpu_stall", 32'(cpu_stall_o), 32'(cpu_req && !(resp && !m_owner)));
      check("dma_ready", 32'(dma_ready_o), 32'(g_dma));
      check("dma_done",  32'(dma_done_o),  32'(resp && m_owner));
      check("mem_r_ena", 32'(mem_r_ena_o), 32'(issue && !m_we));
      check("mem_w_ena", 32'(mem_w_ena_o), 32'(issue && m_we));
      check("mem_addr",  mem_addr_o, m_addr);
      check("mem_wdata", mem_w_data_o, m_wdata);
      check("mem_mask",  32'(mem_sign_mask_o), 32'(m_mask));
      check("cpu_rdata", cpu_r_data_o, exp_cpu_rd);
      check("dma_rdata", dma_r_data_o, exp_dma_rd);
`ifdef DMEM_ARB_STATS_EN
      check("stat_cpu",  32'(stat_cpu_grants_o), 32'(s_cpu));
      check("stat_dma",  32'(stat_dma_grants_o), 32'(s_dma));
      check("stat_conf", 32'(stat_conflicts_o),  32'(s_conf));
`endif
      if (mem_w_ena_o) phys[widx(mem_addr_o)] = mem_w_data_o;
      if (mem_r_ena_o) begin
         rd_due = cyc + L;
         rd_val = phys[widx(mem_addr_o)];
      end
      if (!busy && cpu_req && dma_valid_i) s_conf = sat16(s_conf + 1);
      if (g_cpu) begin
         busy = 1; t0 = cyc; m_owner = 0; last = 0; m_we = cpu_w_ena_i;
         m_addr = cpu_addr_i; m_wdata = cpu_w_data_i; m_mask = cpu_sign_mask_i;
         s_cpu = sat16(s_cpu + 1);
      end
      if (g_dma) begin
         busy = 1; t0 = cyc; m_owner = 1; last = 1; m_we = dma_we_i;
         m_addr = dma_addr_i; m_wdata = dma_w_data_i; m_mask = 4'b0000;
         s_dma = sat16(s_dma + 1);
         dma_pend = 0;
      end
      if (issue && m_we) ref_mem[widx(m_addr)] = m_wdata;
      if (resp) begin
         busy = 0;
         if (!m_owner) cpu_active = 0;
      end
      cyc++;
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'h1000 + 32'($urandom_range(63));
   endfunction

   task automatic cpu_start(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
      cpu_r_ena_i = r; cpu_w_ena_i = w; cpu_addr_i = a;
      cpu_w_data_i = d; cpu_sign_mask_i = m; cpu_active = 1;
   endtask

   task automatic dma_start(input bit we, input logic [31:0] a, input logic [31:0] d);
      dma_valid_i = 1; dma_we_i = we; dma_addr_i = a; dma_w_data_i = d; dma_pend = 1;
   endtask

   task automatic step(input int cpu_pct, input int dma_pct);
      int op;
      tick();
      if (!cpu_active) begin
         if (int'($urandom_range(99)) < cpu_pct) begin
            op = int'($urandom_range(4));
            cpu_start(op < 2 || op == 4, op >= 2, rand_addr(), $urandom, 4'($urandom_range(15)));
         end else begin
            cpu_r_ena_i = 0; cpu_w_ena_i = 0;
         end
      end
      if (!dma_pend) begin
         if (int'($urandom_range(99)) < dma_pct)
            dma_start(1'($urandom_range(1)), rand_addr() & 32'hFFFF_FFFC, $urandom);
         else
            dma_valid_i = 0;
      end
      eval();
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (busy || cpu_active || dma_pend); i++) step(0, 0);
      check("drain_timeout", 32'(busy || cpu_active || dma_pend), 32'd0);
   endtask

   task automatic do_reset();
      rst_ni = 0;
      cpu_r_ena_i = 0; cpu_w_ena_i = 0; dma_valid_i = 0;
      cpu_active = 0; dma_pend = 0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         phys[i]    = 32'hC0DE_0000 | 32'(i);
         ref_mem[i] = phys[i];
      end
      do_reset();

      // CPU load with known memory contents
      phys[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
      tick(); cpu_start(1, 0, 32'h1004, 32'h0, 4'b0010); eval();
      drain();
      check("t1_cpu_rdata", cpu_r_data_o, 32'hDEAD_BEEF);

      // DMA word write, then CPU reads it back
      tick(); dma_start(1, 32'h1010, 32'h1234_5678); eval();
      drain();
      tick(); cpu_start(1, 0, 32'h1010, 32'h0, 4'b0010); eval();
      drain();
      check("t2_readback", cpu_r_data_o, 32'h1234_5678);

      // Contention right after reset, then sustained contention
      do_reset();
      tick(); cpu_start(1, 0, 32'h1008, 32'h0, 4'b0010); dma_start(0, 32'h100C, 32'h0); eval();
      repeat (30) step(100, 100);
      drain();

      // CPU load-byte arrives while DMA is in WAIT
      tick(); dma_start(0, 32'h1014, 32'h0); eval();
      step(0, 0);
      tick(); cpu_start(1, 0, 32'h1003, 32'h0, 4'b0100); eval();
      drain();

      // Asynchronous reset during WAIT
      tick(); dma_start(0, 32'h1018, 32'h0); eval();
      step(0, 0);
      step(0, 0);
      rst_ni = 0;
      #1;
      check("rst_stall", 32'(cpu_stall_o), 32'd0);
      check("rst_ready", 32'(dma_ready_o), 32'd0);
      check("rst_done",  32'(dma_done_o),  32'd0);
      check("rst_mem_r", 32'(mem_r_ena_o), 32'd0);
      check("rst_mem_w", 32'(mem_w_ena_o), 32'd0);
      check("rst_addr",  mem_addr_o, 32'd0);
      check("rst_wdata", mem_w_data_o, 32'd0);
      check("rst_mask",  32'(mem_sign_mask_o), 32'd0);
      check("rst_cpu_rd", cpu_r_data_o, 32'd0);
      check("rst_dma_rd", dma_r_data_o, 32'd0);
      do_reset();
      tick(); cpu_start(1, 0, 32'h1004, 32'h0, 4'b0010); eval();
      drain();

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      for (int r = 0; r < 3; r++) begin
         tick(); cpu_start(0, 1, rand_addr(), $urandom, 4'b0010); dma_start(0, 32'h1020, 32'h0); eval();
         drain();
      end
      for (int r = 0; r < 2; r++) begin
         tick(); cpu_start(1, 0, rand_addr(), 32'h0, 4'b0010); eval();
         drain();
      end
      check("t6_cpu_grants", 32'(stat_cpu_grants_o), 32'd5);
      check("t6_dma_grants", 32'(stat_dma_grants_o), 32'd3);
      check("t6_conflicts",  32'(stat_conflicts_o),  32'd3);
`endif

      // Randomized traffic at varying loads
      for (int p = 0; p < 8; p++) begin
         int cp, dp;
         cp = int'($urandom_range(10, 100));
         dp = int'($urandom_range(10, 100));
         repeat (400) step(cp, dp);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
